// File: rtl/morse_pkg.sv
// Shared types for the Morse letter player.
// Used by the input conditioner, decoder and FSM stages.
package morse_pkg;

    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2
    } cond_state_t;

endpackage

// File: rtl/debounce_bit.sv
// One raw asynchronous input: synchroniser chain followed by a
// stability counter that only moves the output after a long quiet period.
module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_deb
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_deb;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign o_deb  = r_deb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_deb  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            if (w_sync == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_deb <= w_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_input_conditioner.sv
// Start-button and letter-select front end: debounces inputs, turns a press
// into one start pulse and interlocks with the blink stage's finish flag.
module morse_input_conditioner
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter int ACK_TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_btn,
    input  logic [SEL_W-1:0] sw_raw,
    input  logic             finish,
    output logic             start,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             rejected
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    logic             w_en_deb;
    logic [SEL_W-1:0] w_sw_deb;
    logic             w_press;
    logic             w_start_nxt;
    logic             w_rej_nxt;
    cond_state_t      w_state_nxt;

    cond_state_t      r_state;
    logic             r_en_prev;
    logic             r_start;
    logic             r_rej;
    logic [SEL_W-1:0] r_sel;
    logic [TW-1:0]    r_to_cnt;

    debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_db_en (
        .clk  (clk),
        .rst  (rst),
        .i_raw(en_btn),
        .o_deb(w_en_deb)
    );

    for (genvar g = 0; g < SEL_W; g++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_db_sw (
            .clk  (clk),
            .rst  (rst),
            .i_raw(sw_raw[g]),
            .o_deb(w_sw_deb[g])
        );
    end

    // Only the debounced rising edge counts; releases are ignored.
    assign w_press = w_en_deb & ~r_en_prev;

    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = 1'b0;
        w_rej_nxt   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_press) begin
                    if (finish) begin
                        w_start_nxt = 1'b1;
                        w_state_nxt = WAIT_ACK;
                    end else begin
                        w_rej_nxt = 1'b1;
                    end
                end
            end
            WAIT_ACK: begin
                w_rej_nxt = w_press;
                if (!finish) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                w_rej_nxt = w_press;
                if (finish) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_en_prev <= 1'b0;
            r_start   <= 1'b0;
            r_rej     <= 1'b0;
            r_sel     <= '0;
            r_to_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_en_prev <= w_en_deb;
            r_start   <= w_start_nxt;
            r_rej     <= w_rej_nxt;
            if (w_start_nxt) begin
                r_sel <= w_sw_deb;
            end
            if (r_state == WAIT_ACK && finish) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign start    = r_start;
    assign rejected = r_rej;
    assign sel      = r_sel;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_morse_input_conditioner.sv
// Directed bench for the Morse input conditioner with short debounce
// and timeout settings.
module tb_morse_input_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_btn;
    logic [2:0] sw_raw;
    logic       finish;
    logic       start;
    logic [2:0] sel;
    logic       busy;
    logic       rejected;

    int errors  = 0;
    int checks  = 0;
    int n_start = 0;
    int n_rej   = 0;
    int base;

    morse_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2),
        .ACK_TIMEOUT    (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en_btn  (en_btn),
        .sw_raw  (sw_raw),
        .finish  (finish),
        .start   (start),
        .sel     (sel),
        .busy    (busy),
        .rejected(rejected)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        if (start) n_start++;
        if (rejected) n_rej++;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        en_btn = 1'b0;
        sw_raw = 3'b101;
        finish = 1'b1;
        tick_n(2);
        chk("rst_start", {7'd0, start}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_rej", {7'd0, rejected}, 8'd0);
        chk("rst_sel", {5'd0, sel}, 8'd0);
        rst = 1'b0;
        tick_n(10);

        // Clean press: start exactly 7 edges after the raw edge
        en_btn = 1'b1;
        tick_n(6);
        chk("clean_early", {7'd0, start}, 8'd0);
        tick();
        chk("clean_start", {7'd0, start}, 8'd1);
        chk("clean_sel", {5'd0, sel}, 8'h05);
        chk("clean_busy", {7'd0, busy}, 8'd1);

        // Handshake: blink stage goes busy
        finish = 1'b0;
        tick();
        chk("clean_pulse", {7'd0, start}, 8'd0);
        chk("ack_busy", {7'd0, busy}, 8'd1);

        // Busy press with a switch change: rejected, sel held
        sw_raw = 3'b010;
        en_btn = 1'b0;
        tick_n(8);
        base = n_start;
        en_btn = 1'b1;
        tick_n(6);
        chk("busy_rej_early", {7'd0, rejected}, 8'd0);
        tick();
        chk("busy_rej", {7'd0, rejected}, 8'd1);
        chk("busy_nostart", {7'd0, start}, 8'd0);
        chk("busy_sel", {5'd0, sel}, 8'h05);
        tick();
        chk("busy_rej_pulse", {7'd0, rejected}, 8'd0);
        tick_n(13);
        chk("busy_starts", 8'(n_start - base), 8'd0);
        chk("busy_hold", {7'd0, busy}, 8'd1);

        // Blink done: busy falls one cycle after finish rises
        finish = 1'b1;
        chk("done_busy_pre", {7'd0, busy}, 8'd1);
        tick();
        chk("done_busy", {7'd0, busy}, 8'd0);

        // Second press gives a new start with the new letter
        en_btn = 1'b0;
        tick_n(8);
        en_btn = 1'b1;
        tick_n(6);
        chk("p2_early", {7'd0, start}, 8'd0);
        tick();
        chk("p2_start", {7'd0, start}, 8'd1);
        chk("p2_sel", {5'd0, sel}, 8'h02);

        // Timeout: finish never drops
        tick_n(7);
        chk("to_busy_hold", {7'd0, busy}, 8'd1);
        tick();
        chk("to_busy_drop", {7'd0, busy}, 8'd0);

        // Bounce: 2-cycle toggles never pass the debouncer
        en_btn = 1'b0;
        tick_n(8);
        base = n_start;
        for (int i = 0; i < 10; i++) begin
            en_btn = (i % 2 == 0);
            tick_n(2);
        end
        en_btn = 1'b1;
        tick_n(6);
        chk("bnc_none", 8'(n_start - base), 8'd0);
        tick();
        chk("bnc_start", {7'd0, start}, 8'd1);
        chk("bnc_count", 8'(n_start - base), 8'd1);

        // Reset during WAIT_DONE with the button still held
        finish = 1'b0;
        tick();
        chk("rmp_busy", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        finish = 1'b1;
        chk("rmp_start", {7'd0, start}, 8'd0);
        chk("rmp_busy0", {7'd0, busy}, 8'd0);
        chk("rmp_rej", {7'd0, rejected}, 8'd0);
        chk("rmp_sel", {5'd0, sel}, 8'd0);
        base = n_start;
        tick_n(6);
        chk("rmp_early", 8'(n_start - base), 8'd0);
        tick();
        chk("rmp_restart", {7'd0, start}, 8'd1);
        chk("rmp_sel2", {5'd0, sel}, 8'h02);
        tick_n(12);
        chk("rmp_once", 8'(n_start - base), 8'd1);
        chk("rmp_idle", {7'd0, busy}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
